// File: rtl/qoa_pkg.sv
// -----------------------------------------------------------------------------
// qoa_pkg
// Shared definitions for the QOA decoder front end and decoder core.
//   QOA_BYTE_W / QOA_SAMPLE_W : widths of a received SPI byte and of a sample
//   sess_state_t              : SPI chip-select session state
//   TX_BIT_FIRST              : index of the first sample bit shifted out (MSB)
//   is_tx_cmd()               : byte requests transmission of the current sample
//   is_sample_cmd()           : byte carries sample payload for the decoder
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package qoa_pkg;

    localparam int QOA_BYTE_W   = 8;
    localparam int QOA_SAMPLE_W = 16;

    localparam logic [3:0] TX_BIT_FIRST = 4'hF;

    typedef enum logic {
        SESS_IDLE   = 1'b0,
        SESS_ACTIVE = 1'b1
    } sess_state_t;

    function automatic logic is_tx_cmd(input logic [QOA_BYTE_W-1:0] cmd_byte);
        return cmd_byte[7] & ~cmd_byte[0];
    endfunction

    function automatic logic is_sample_cmd(input logic [QOA_BYTE_W-1:0] cmd_byte);
        return cmd_byte[0];
    endfunction

endpackage

// File: rtl/qoa_sync_edge.sv
// -----------------------------------------------------------------------------
// qoa_sync_edge
// Brings one asynchronous pin into the sys_clk domain through SYNC_STAGES
// flops, keeps one history flop behind the synchronized copy and reports
// single-cycle rise/fall pulses on it.
//   SYNC_STAGES : synchronizer depth (2..3)
//   RST_VAL     : idle level of the pin; all flops reset to it so that no
//                 spurious edge appears when reset is released
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   pin_raw            : asynchronous input pin
//   level              : synchronized pin level
//   rise, fall         : one-cycle pulses on synchronized level transitions
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module qoa_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic pin_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/qoa_spi_slave.sv
// -----------------------------------------------------------------------------
// qoa_spi_slave
// SPI mode-0 slave front end for the QOA decoder. Synchronizes the SPI pins,
// assembles MOSI bits into bytes and, after a TX command byte, shifts the
// decoder's 16-bit sample word out on MISO, MSB first.
// Ports:
//   sys_clk, sys_rst_n : system clock, asynchronous active-low reset
//   spi_sclk, spi_cs_n, spi_mosi : raw SPI pins (asynchronous)
//   spi_miso    : registered serial output, changes on synced SCLK falls
//   tx_word     : sample word to transmit (decoder spi_out)
//   data_rdy    : one-cycle strobe, spi_in holds a freshly completed byte
//   spi_in      : last received byte, held until the next one completes
//   spi_out_bit : index of the tx_word bit to be driven on the next fall
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module qoa_spi_slave
    import qoa_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    input  logic [QOA_SAMPLE_W-1:0] tx_word,
    output logic                    data_rdy,
    output logic [QOA_BYTE_W-1:0]   spi_in,
    output logic [3:0]              spi_out_bit
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    // All three pins share the same depth so MOSI is aligned to its SCLK edge.
    qoa_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pin_raw   (spi_sclk),
        .level     (sclk_lvl),
        .rise      (sclk_rise),
        .fall      (sclk_fall)
    );

    qoa_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pin_raw   (spi_cs_n),
        .level     (cs_lvl),
        .rise      (cs_rise),
        .fall      (cs_fall)
    );

    qoa_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pin_raw   (spi_mosi),
        .level     (mosi_s),
        .rise      (mosi_rise),
        .fall      (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = sclk_lvl | cs_lvl | mosi_rise | mosi_fall;

    sess_state_t             state;
    logic [2:0]              bit_cnt;
    logic                    tx_active;
    logic [QOA_BYTE_W-2:0]   shreg;
    logic [QOA_BYTE_W-1:0]   rx_byte;

    // Byte as it stands once the current MOSI sample is shifted in.
    assign rx_byte = {shreg, mosi_s};

    logic shift_en;
    assign shift_en = (state == SESS_ACTIVE) && !cs_rise && sclk_rise;

    // Shift register is pure data: every byte overwrites all seven bits
    // before it is used, so it needs no reset.
    always_ff @(posedge sys_clk) begin
        if (shift_en) begin
            shreg <= rx_byte[QOA_BYTE_W-2:0];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= SESS_IDLE;
            bit_cnt     <= 3'd0;
            tx_active   <= 1'b0;
            spi_in      <= '0;
            data_rdy    <= 1'b0;
            spi_miso    <= 1'b0;
            spi_out_bit <= TX_BIT_FIRST;
        end else begin
            data_rdy <= 1'b0;
            case (state)
                SESS_IDLE: begin
                    // SCLK activity is ignored until chip select asserts.
                    if (cs_fall) begin
                        state       <= SESS_ACTIVE;
                        bit_cnt     <= 3'd0;
                        tx_active   <= 1'b0;
                        spi_out_bit <= TX_BIT_FIRST;
                    end
                end
                SESS_ACTIVE: begin
                    if (cs_rise) begin
                        // Session aborted: drop any partial byte or frame,
                        // spi_in keeps the last complete byte.
                        state       <= SESS_IDLE;
                        bit_cnt     <= 3'd0;
                        tx_active   <= 1'b0;
                        spi_out_bit <= TX_BIT_FIRST;
                        spi_miso    <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                spi_in   <= rx_byte;
                                data_rdy <= 1'b1;
                                // A TX command also restarts a running frame.
                                if (is_tx_cmd(rx_byte)) begin
                                    tx_active   <= 1'b1;
                                    spi_out_bit <= TX_BIT_FIRST;
                                end
                            end
                        end
                        // Rise and fall of the same synced SCLK are never
                        // simultaneous, so the RX and TX updates do not collide.
                        if (sclk_fall) begin
                            if (tx_active) begin
                                spi_miso <= tx_word[spi_out_bit];
                                if (spi_out_bit == 4'd0) begin
                                    tx_active   <= 1'b0;
                                    spi_out_bit <= TX_BIT_FIRST;
                                end else begin
                                    spi_out_bit <= spi_out_bit - 4'd1;
                                end
                            end else begin
                                spi_miso <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= SESS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qoa_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_qoa_spi_slave
// Drives the slave as an SPI mode-0 master with randomized SCLK rates and
// bytes, and compares received bytes, MISO bits and spi_out_bit against a
// queue-based model of the byte/frame protocol.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_qoa_spi_slave;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] tx_word;
    logic        data_rdy;
    logic [7:0]  spi_in;
    logic [3:0]  spi_out_bit;

    qoa_spi_slave #(.SYNC_STAGES(2)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .tx_word     (tx_word),
        .data_rdy    (data_rdy),
        .spi_in      (spi_in),
        .spi_out_bit (spi_out_bit)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] exp_q[$];   // bytes the master completed in this session
    logic [7:0] rx_q[$];    // bytes the slave reported via data_rdy
    logic       miso_q[$];  // MISO bits still owed to the master, in order
    int         half_ns;
    logic       rdy_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (data_rdy === 1'b1) begin
            check_val("rdy_width", 32'(rdy_prev), 32'd0);
            rx_q.push_back(spi_in);
        end
        rdy_prev <= data_rdy;
    end

    task automatic start_session();
        half_ns  = 10 * $urandom_range(5, 7);
        spi_cs_n = 1'b0;
        #(half_ns);
    endtask

    // Sends the first nbits of b (MSB first); samples MISO on each rise.
    task automatic xfer_byte(input logic [7:0] b, input int nbits);
        logic exp_bit;
        int   exp_idx;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            #(half_ns);
            spi_sclk = 1'b1;
            if (miso_q.size() > 0) exp_bit = miso_q.pop_front();
            else                   exp_bit = 1'b0;
            exp_idx = (miso_q.size() == 0) ? 15 : miso_q.size() - 1;
            check_val("miso", 32'(spi_miso), 32'(exp_bit));
            check_val("out_bit", 32'(spi_out_bit), 32'(exp_idx));
            #(half_ns);
            spi_sclk = 1'b0;
        end
        if (nbits == 8) begin
            exp_q.push_back(b);
            if (b[7] && !b[0]) begin
                miso_q.delete();
                for (int k = 15; k >= 0; k--) miso_q.push_back(tx_word[k]);
            end
        end
    endtask

    task automatic compare_rx();
        check_val("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_val("rx_byte", 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic end_session();
        #(half_ns);
        spi_cs_n = 1'b1;
        miso_q.delete();
        #60;
        check_val("idle_miso", 32'(spi_miso), 32'd0);
        check_val("idle_bit", 32'(spi_out_bit), 32'd15);
        compare_rx();
    endtask

    initial begin
        logic [7:0] b;
        int         nb;
        int         nbits;

        sys_rst_n = 1'b0;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        tx_word   = 16'h0000;

        #22;
        check_val("rst_miso", 32'(spi_miso), 32'd0);
        check_val("rst_rdy", 32'(data_rdy), 32'd0);
        check_val("rst_spi_in", 32'(spi_in), 32'd0);
        check_val("rst_out_bit", 32'(spi_out_bit), 32'd15);
        #10;
        sys_rst_n = 1'b1;
        #30;

        // Single byte
        start_session();
        xfer_byte(8'hA5, 8);
        end_session();

        // Back-to-back bytes in one session
        start_session();
        xfer_byte(8'h01, 8);
        xfer_byte(8'h3C, 8);
        xfer_byte(8'hFE, 8);
        end_session();

        // Full TX frame plus one more byte with MISO back at 0
        tx_word = 16'hBEEF;
        start_session();
        xfer_byte(8'h80, 8);
        xfer_byte(8'($urandom), 8);
        xfer_byte(8'($urandom), 8);
        xfer_byte(8'h33, 8);
        end_session();

        // Aborted partial byte, then a clean one
        start_session();
        xfer_byte(8'hFF, 5);
        end_session();
        start_session();
        xfer_byte(8'h12, 8);
        end_session();

        // TX frame aborted after 6 bits, then restarted
        tx_word = 16'hC0DE;
        start_session();
        xfer_byte(8'h80, 8);
        xfer_byte(8'h00, 6);
        end_session();
        start_session();
        xfer_byte(8'h80, 8);
        xfer_byte(8'h55, 8);
        xfer_byte(8'hAA, 8);
        end_session();

        // Asynchronous reset mid-byte
        start_session();
        xfer_byte(8'hC3, 8);
        xfer_byte(8'hFF, 4);
        #7;
        sys_rst_n = 1'b0;
        #1;
        check_val("arst_miso", 32'(spi_miso), 32'd0);
        check_val("arst_rdy", 32'(data_rdy), 32'd0);
        check_val("arst_spi_in", 32'(spi_in), 32'd0);
        check_val("arst_out_bit", 32'(spi_out_bit), 32'd15);
        #22;
        sys_rst_n = 1'b1;
        end_session();
        start_session();
        xfer_byte(8'h5A, 8);
        end_session();

        // Randomized sessions: mixed data and TX commands, some truncated
        for (int s = 0; s < 25; s++) begin
            tx_word = 16'($urandom);
            start_session();
            nb = $urandom_range(1, 5);
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 2) == 0) b = {1'b1, b[6:1], 1'b0};
                nbits = 8;
                if (j == nb - 1 && $urandom_range(0, 3) == 0) nbits = $urandom_range(1, 7);
                xfer_byte(b, nbits);
            end
            end_session();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
